// File: rtl/init_mem_multi.sv
// Single-port RAM initialiser: fills addresses 0..DEPTH-1 with an identity,
// constant or descending pattern. Optional read-back check under INIT_MEM_VERIFY_EN.
module init_mem_multi #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
`ifdef INIT_MEM_VERIFY_EN
    input  logic [DATA_W-1:0] ram_q,
    output logic              verify_error,
    output logic [ADDR_W-1:0] err_addr,
`endif
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done_initializing,
    output logic [1:0]        state_dbg
);

    localparam int PW = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1;
    localparam int unsigned LAST_I = DEPTH - 1;
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST_I);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
`ifdef INIT_MEM_VERIFY_EN
    localparam logic [1:0] S_VERIFY = 2'd3;
`endif

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wren_q, wren_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] fill_q, fill_d;
`ifdef INIT_MEM_VERIFY_EN
    logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
    logic              chk_vld_q, chk_vld_d;
    logic              sweep_done_q, sweep_done_d;
    logic              verr_q, verr_d;
    logic [ADDR_W-1:0] eaddr_q, eaddr_d;
`endif

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                  input logic [DATA_W-1:0] f,
                                                  input logic [ADDR_W-1:0] a);
        logic [PW-1:0] wide_a;
        logic [PW-1:0] desc;
        wide_a = PW'(a);
        desc   = PW'(LAST_I) - wide_a;
        case (m)
            2'd1:    pattern = f;
            2'd2:    pattern = desc[DATA_W-1:0];
            default: pattern = wide_a[DATA_W-1:0];
        endcase
    endfunction

    // Handshake: start is accepted on any edge where it is high in IDLE or DONE;
    // busy follows from the next cycle, and done_initializing is a level that
    // stays high until the next accepted start. start is ignored while busy.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = wren_q;
        busy_d  = busy_q;
        done_d  = done_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
`ifdef INIT_MEM_VERIFY_EN
        chk_addr_d   = chk_addr_q;
        chk_vld_d    = chk_vld_q;
        sweep_done_d = sweep_done_q;
        verr_d       = verr_q;
        eaddr_d      = eaddr_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d  = mode;
                    fill_d  = fill_value;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    addr_d  = '0;
                    wren_d  = 1'b1;
                    data_d  = pattern(mode, fill_value, '0);
                    state_d = S_WRITE;
`ifdef INIT_MEM_VERIFY_EN
                    chk_vld_d    = 1'b0;
                    sweep_done_d = 1'b0;
                    verr_d       = 1'b0;
                    eaddr_d      = '0;
`endif
                end
            end
            S_WRITE: begin
                if (addr_q == LAST_A) begin
                    wren_d = 1'b0;
                    addr_d = '0;
`ifdef INIT_MEM_VERIFY_EN
                    state_d = S_VERIFY;
`else
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end else begin
                    addr_d = addr_q + 1'b1;
                    data_d = pattern(mode_q, fill_q, addr_q + 1'b1);
                end
            end
`ifdef INIT_MEM_VERIFY_EN
            S_VERIFY: begin
                // ram_q now holds the word for the address issued one cycle earlier.
                if (chk_vld_q && !verr_q &&
                    (ram_q != pattern(mode_q, fill_q, chk_addr_q))) begin
                    verr_d  = 1'b1;
                    eaddr_d = chk_addr_q;
                end
                if (sweep_done_q) begin
                    chk_vld_d = 1'b0;
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    chk_addr_d = addr_q;
                    chk_vld_d  = 1'b1;
                    if (addr_q == LAST_A) begin
                        sweep_done_d = 1'b1;
                        addr_d       = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= '0;
            fill_q  <= '0;
`ifdef INIT_MEM_VERIFY_EN
            chk_addr_q   <= '0;
            chk_vld_q    <= 1'b0;
            sweep_done_q <= 1'b0;
            verr_q       <= 1'b0;
            eaddr_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
`ifdef INIT_MEM_VERIFY_EN
            chk_addr_q   <= chk_addr_d;
            chk_vld_q    <= chk_vld_d;
            sweep_done_q <= sweep_done_d;
            verr_q       <= verr_d;
            eaddr_q      <= eaddr_d;
`endif
        end
    end

    assign ram_address       = addr_q;
    assign ram_data          = data_q;
    assign ram_wren          = wren_q;
    assign busy              = busy_q;
    assign done_initializing = done_q;
    assign state_dbg         = state_q;
`ifdef INIT_MEM_VERIFY_EN
    assign verify_error = verr_q;
    assign err_addr     = eaddr_q;
`endif

endmodule

// File: tb/tb_init_mem_multi.sv
// Scoreboard bench for init_mem_multi: a default 256-word instance and a
// 4-bit-address, 12-word instance, each with a RAM model and write monitor.
module tb_init_mem_multi;

`ifdef INIT_MEM_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // instance A: defaults
  logic       start_a = 1'b0;
  logic [1:0] mode_a = 2'd0;
  logic [7:0] fill_a = 8'h00;
  logic [7:0] ram_address_a, ram_data_a;
  logic       ram_wren_a, busy_a, done_a;
  logic [1:0] state_a;
  logic [7:0] mem_a [256];
  bit         bad_a;
  logic [15:0] exp_a [$];

  // instance B: ADDR_W=4, DEPTH=12
  logic       start_b = 1'b0;
  logic [1:0] mode_b = 2'd0;
  logic [7:0] fill_b = 8'h00;
  logic [3:0] ram_address_b;
  logic [7:0] ram_data_b;
  logic       ram_wren_b, busy_b, done_b;
  logic [1:0] state_b;
  logic [7:0] mem_b [16];
  bit         oob_b;
  logic [11:0] exp_b [$];

`ifdef INIT_MEM_VERIFY_EN
  logic [7:0] ram_q_a, ram_q_b;
  logic       verr_a, verr_b;
  logic [7:0] eaddr_a;
  logic [3:0] eaddr_b;
`endif

  init_mem_multi dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mode(mode_a), .fill_value(fill_a),
`ifdef INIT_MEM_VERIFY_EN
    .ram_q(ram_q_a), .verify_error(verr_a), .err_addr(eaddr_a),
`endif
    .ram_address(ram_address_a), .ram_data(ram_data_a), .ram_wren(ram_wren_a),
    .busy(busy_a), .done_initializing(done_a), .state_dbg(state_a)
  );

  init_mem_multi #(.ADDR_W(4), .DATA_W(8), .DEPTH(12)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode_b), .fill_value(fill_b),
`ifdef INIT_MEM_VERIFY_EN
    .ram_q(ram_q_b), .verify_error(verr_b), .err_addr(eaddr_b),
`endif
    .ram_address(ram_address_b), .ram_data(ram_data_b), .ram_wren(ram_wren_b),
    .busy(busy_b), .done_initializing(done_b), .state_dbg(state_b)
  );

  // RAM models; A can be told to misread address 37
  always @(posedge clk) begin
    if (ram_wren_a) mem_a[ram_address_a] <= ram_data_a;
    if (ram_wren_b) mem_b[ram_address_b] <= ram_data_b;
    if (ram_wren_b && (ram_address_b >= 4'd12)) oob_b <= 1'b1;
`ifdef INIT_MEM_VERIFY_EN
    ram_q_a <= (bad_a && (ram_address_a == 8'd37)) ? 8'h00 : mem_a[ram_address_a];
    ram_q_b <= mem_b[ram_address_b];
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int m, input logic [7:0] f, input int a, input int depth);
    int v;
    case (m)
      1: v = int'(f);
      2: v = depth - 1 - a;
      default: v = a;
    endcase
    return 8'(v);
  endfunction

  // write monitors: every write the DUT presents must match the queue head
  always @(negedge clk) begin
    if (reset && (ram_wren_a === 1'b1)) begin
      if (exp_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr_a_unexpected: got addr 0x%0h data 0x%0h, expected no write", ram_address_a, ram_data_a);
      end else begin
        check("wr_a", 32'({ram_address_a, ram_data_a}), 32'(exp_a.pop_front()));
      end
    end
    if (reset && (ram_wren_b === 1'b1)) begin
      if (exp_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr_b_unexpected: got addr 0x%0h data 0x%0h, expected no write", ram_address_b, ram_data_b);
      end else begin
        check("wr_b", 32'({ram_address_b, ram_data_b}), 32'(exp_b.pop_front()));
      end
    end
  end

  task automatic run_a(input int m, input logic [7:0] f, input bit chg, input bit rs, input bit bad);
    int lat;
    int bad_cnt;
    lat = VER ? 2 * 256 + 1 : 256;
    for (int i = 0; i < 256; i++) exp_a.push_back({8'(i), pat(m, f, i, 256)});
    bad_a = bad;
    @(negedge clk);
    mode_a = 2'(m); fill_a = f; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("a_start_busy", 32'(busy_a), 32'd1);
    check("a_start_done", 32'(done_a), 32'd0);
    check("a_start_state", 32'(state_a), 32'd1);
`ifdef INIT_MEM_VERIFY_EN
    check("a_start_verr", 32'(verr_a), 32'd0);
`endif
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (chg && k == 50) begin mode_a = 2'd0; fill_a = 8'h3C; end
      if (rs && k == 99) start_a = 1'b1;
      if (rs && k == 100) start_a = 1'b0;
      if (k == lat - 1) begin
        check("a_busy_before_done", 32'(busy_a), 32'd1);
        check("a_done_early", 32'(done_a), 32'd0);
      end
    end
    check("a_done", 32'(done_a), 32'd1);
    check("a_busy_end", 32'(busy_a), 32'd0);
    check("a_state_end", 32'(state_a), 32'd2);
    check("a_wren_end", 32'(ram_wren_a), 32'd0);
    check("a_addr_end", 32'(ram_address_a), 32'd0);
    check("a_writes_left", 32'(exp_a.size()), 32'd0);
`ifdef INIT_MEM_VERIFY_EN
    if (bad && pat(m, f, 37, 256) != 8'h00) begin
      check("a_verr", 32'(verr_a), 32'd1);
      check("a_err_addr", 32'(eaddr_a), 32'd37);
    end else begin
      check("a_verr", 32'(verr_a), 32'd0);
    end
`endif
    bad_cnt = 0;
    for (int i = 0; i < 256; i++) if (mem_a[i] !== pat(m, f, i, 256)) bad_cnt++;
    check("a_ram_contents", 32'(bad_cnt), 32'd0);
    bad_a = 1'b0;
  endtask

  task automatic run_b(input int m, input logic [7:0] f);
    int lat;
    int bad_cnt;
    lat = VER ? 2 * 12 + 1 : 12;
    for (int i = 0; i < 12; i++) exp_b.push_back({4'(i), pat(m, f, i, 12)});
    @(negedge clk);
    mode_b = 2'(m); fill_b = f; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check("b_start_done", 32'(done_b), 32'd0);
    check("b_start_busy", 32'(busy_b), 32'd1);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin mode_b = 2'd1; fill_b = 8'hFF; end
      if (k == lat - 1) check("b_done_early", 32'(done_b), 32'd0);
    end
    check("b_done", 32'(done_b), 32'd1);
    check("b_busy_end", 32'(busy_b), 32'd0);
    check("b_writes_left", 32'(exp_b.size()), 32'd0);
`ifdef INIT_MEM_VERIFY_EN
    check("b_verr", 32'(verr_b), 32'd0);
`endif
    bad_cnt = 0;
    for (int i = 0; i < 12; i++) if (mem_b[i] !== pat(m, f, i, 12)) bad_cnt++;
    check("b_ram_contents", 32'(bad_cnt), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_addr", 32'(ram_address_a), 32'd0);
    check("rst_a_data", 32'(ram_data_a), 32'd0);
    check("rst_a_wren", 32'(ram_wren_a), 32'd0);
    check("rst_a_busy", 32'(busy_a), 32'd0);
    check("rst_a_done", 32'(done_a), 32'd0);
    check("rst_a_state", 32'(state_a), 32'd0);
    check("rst_b_wren", 32'(ram_wren_b), 32'd0);
    check("rst_b_done", 32'(done_b), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    run_a(0, 8'h00, 1'b0, 1'b1, 1'b0);   // identity, stray start mid-fill
    run_a(1, 8'hA5, 1'b1, 1'b0, 1'b0);   // constant, mode/fill changed mid-fill
    run_a(2, 8'h00, 1'b0, 1'b0, 1'b0);   // descending 255..0
    run_a(3, 8'h77, 1'b0, 1'b0, 1'b0);   // reserved mode acts as identity

    // asynchronous reset mid-fill, away from any clock edge
    for (int i = 0; i < 256; i++) exp_a.push_back({8'(i), 8'(i)});
    @(negedge clk);
    mode_a = 2'd0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (50) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst_addr", 32'(ram_address_a), 32'd0);
    check("arst_data", 32'(ram_data_a), 32'd0);
    check("arst_wren", 32'(ram_wren_a), 32'd0);
    check("arst_busy", 32'(busy_a), 32'd0);
    check("arst_done", 32'(done_a), 32'd0);
    check("arst_state", 32'(state_a), 32'd0);
    check("arst_writes_done", 32'(exp_a.size()), 32'd206);
    exp_a.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    run_a(0, 8'h00, 1'b0, 1'b0, 1'b1);   // RAM misreads address 37
    run_a(0, 8'h00, 1'b0, 1'b0, 1'b0);   // clean RAM

    run_b(2, 8'h00);
    run_b(0, 8'h00);
    run_b(1, 8'h3C);
    check("b_no_write_above_depth", 32'(oob_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/init_mem_multi.md
Name: init_mem_multi

Overview:
- Parametrised successor to the S-box initialiser in the RC4 datapath. Fills an on-chip RAM (M10K, single-port) with one of three patterns:
  - identity: data = address
  - constant fill
  - descending: data = DEPTH-1-address
- Sits between the top-level decrypt FSM and the S-memory write port.
- Runs on a start/done handshake, so the top FSM can re-initialise S for every key trial without a reset.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 256, number of words written, from address 0 to DEPTH-1. Must satisfy 1 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  system clock (50 MHz); all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  single-cycle or level request. Sampled only in IDLE or DONE.
- mode  in  2  pattern select, latched at start: 0 identity, 1 constant, 2 descending, 3 reserved (treated as identity).
- fill_value  in  DATA_W  constant for mode 1, latched at start.
- ram_address  out  ADDR_W  RAM address, registered.
- ram_data  out  DATA_W  RAM write data, registered.
- ram_wren  out  1  RAM write enable, registered.
- busy  out  1  high from the cycle after start is accepted until done_initializing rises.
- done_initializing  out  1  level; high once the fill completes, cleared when the next start is accepted.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ram_address=0, ram_data=0, ram_wren=0, busy=0, done_initializing=0; latched mode/fill cleared to 0. Reset mid-fill aborts immediately; partial RAM contents are left as-is.
- States: IDLE, WRITE, DONE (plus VERIFY, see Optional Feature).
- IDLE or DONE with start=1 at edge T:
  - latch mode and fill_value; clear done_initializing.
  - enter WRITE with ram_address=0, ram_wren=1, ram_data=pattern(0); busy=1.
- WRITE: one write per cycle.
  - ram_wren=1 for exactly DEPTH consecutive cycles; addresses 0,1,...,DEPTH-1 in order.
  - ram_data = pattern(address), presented in the same cycle as its address.
  - On the edge that retires address DEPTH-1: ram_wren=0, ram_address returns to 0, state=DONE, busy=0, done_initializing=1.
  - Start-to-done latency: done_initializing rises at edge T+DEPTH.
- Pattern widths:
  - identity: address zero-extended or truncated to DATA_W (low bits kept).
  - descending: (DEPTH-1-address), computed at max(ADDR_W,DATA_W)+1 bits, low DATA_W bits kept.
  - constant: fill_value.
- start while busy: ignored. Changes to mode or fill_value during WRITE have no effect.
- DONE: outputs hold (ram_wren=0, done_initializing=1) until start or reset.
- DEPTH < 2**ADDR_W: no write to addresses >= DEPTH. Counter terminal compare is against DEPTH-1, not wrap-around.
- DEPTH=1: a single write cycle; done at T+1.

Optional Feature:
- Macro INIT_MEM_VERIFY_EN.
- Defined:
  - adds ports ram_q (in, DATA_W; RAM read data, valid one cycle after its address), verify_error (out, 1), err_addr (out, ADDR_W).
  - after WRITE, enter VERIFY: ram_wren=0, ram_address sweeps 0..DEPTH-1, one per cycle.
  - each ram_q is compared against pattern(address issued the previous cycle); DEPTH+1 cycles total for the pipeline drain.
  - verify_error is sticky and err_addr captures the first mismatching address.
  - both are cleared when start is accepted; both reset to 0.
  - done_initializing rises at T+DEPTH+DEPTH+1; busy stays high throughout VERIFY.
- Undefined: no extra ports, no VERIFY state, timing as in Behaviour.

Test Plan:
- Defaults, mode=0, 1-cycle start at T → wren high T..T+255, RAM[i]=i for i in 0..255, done_initializing=1 at T+256, busy=0 at T+256.
- mode=1, fill_value=8'hA5 → all 256 words = 8'hA5; mode changed to 0 mid-fill → still all 8'hA5.
- ADDR_W=4, DATA_W=8, DEPTH=12, mode=2 → RAM[0..11] = 11..0, no write to addresses 12..15, done at T+12.
- Second start pulse at T+100 during fill → ignored, single 256-write pass. Start again in DONE → done drops next cycle, full re-fill.
- reset=0 asynchronously at T+50 → all outputs 0 before the next clock edge, state IDLE. After release, start → fill restarts at address 0.
- INIT_MEM_VERIFY_EN, RAM model forcing address 37 to read 8'h00 in mode 0 → verify_error=1, err_addr=37, done at T+513. Clean RAM → verify_error=0.
